// File: rtl/kd_pkg.sv
// rtl/kd_pkg.sv - shared k-d tree node layout, traverser states and dim clamp helper
package kd_pkg;

    // Width of the split-dimension field in a node word
    localparam int NODE_DIMW = 3;

    // Default median width; software and leaf search share this node-word layout
    localparam int KD_DATA_WIDTH = 11;

    // Node-word field positions: median in the low bits, split dim directly above it
    localparam int NODE_MED_LSB = 0;
    localparam int NODE_DIM_LSB = KD_DATA_WIDTH;

    // One internal node in the default layout
    typedef struct packed {
        logic [NODE_DIMW-1:0]     dim;
        logic [KD_DATA_WIDTH-1:0] median;
    } node_t;

    // Traverser control states
    typedef enum logic [1:0] {
        TRAV_IDLE   = 2'd0,
        TRAV_WALK   = 2'd1,
        TRAV_RESULT = 2'd2
    } trav_state_t;

    // Flat state constants for the FSM register
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WALK   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    // A split dim beyond the patch would select nothing; fold it onto the last element
    function automatic logic [NODE_DIMW-1:0] clamp_dim(input logic [NODE_DIMW-1:0] dim,
                                                       input int unsigned patch_size);
        if (32'(dim) >= patch_size) begin
            return NODE_DIMW'(patch_size - 1);
        end
        return dim;
    endfunction

endpackage

// File: rtl/kd_node_mem.sv
// rtl/kd_node_mem.sv - internal node array, registered bus read port, combinational walk port (KD_NODE_RESET_EN)
module kd_node_mem
    import kd_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_ADDRW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LEAF_ADDRW-1:0] addr,
    input  logic [NODE_DIMW-1:0]  wr_dim,
    input  logic [DATA_WIDTH-1:0] wr_med,
    output logic [31:0]           rd_data,
    input  logic [LEAF_ADDRW-1:0] walk_addr,
    output logic [NODE_DIMW-1:0]  walk_dim,
    output logic [DATA_WIDTH-1:0] walk_med
);

    localparam int NUM_NODES = 2 ** LEAF_ADDRW;
    localparam int PADW      = 32 - NODE_DIMW - DATA_WIDTH;

    logic [NODE_DIMW-1:0]  dim_q [NUM_NODES];
    logic [DATA_WIDTH-1:0] med_q [NUM_NODES];
    logic                  node_wr;

    // Slot 0 is not a tree node, so writes aimed at it are dropped
    assign node_wr = wr_en && (addr != '0);

`ifdef KD_NODE_RESET_EN
    // Node storage with reset: an unwritten tree reads as all {dim 0, median 0}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                dim_q[i] <= '0;
                med_q[i] <= '0;
            end
        end else if (node_wr) begin
            dim_q[addr] <= wr_dim;
            med_q[addr] <= wr_med;
        end
    end
`else
    // Node storage without reset: contents are meaningless until software loads the tree
    always_ff @(posedge clk) begin
        if (node_wr) begin
            dim_q[addr] <= wr_dim;
            med_q[addr] <= wr_med;
        end
    end
`endif

    // Bus read: registered, only refreshed on read cycles, slot 0 always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (!wr_en) begin
            if (addr == '0) begin
                rd_data <= '0;
            end else begin
                rd_data <= {{PADW{1'b0}}, dim_q[addr], med_q[addr]};
            end
        end
    end

    // Walk port reads the pre-edge array, so a same-cycle write is seen only next cycle
    assign walk_dim = dim_q[walk_addr];
    assign walk_med = med_q[walk_addr];

endmodule

// File: rtl/kd_tree_traverser.sv
// rtl/kd_tree_traverser.sv - walks a query patch root to leaf over heap-ordered nodes (KD_NODE_RESET_EN)
module kd_tree_traverser
    import kd_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int IDX_WIDTH  = 9,
    parameter int NUM_LEAVES = 64,
    parameter int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wbs_node_mem_web,
    input  logic [31:0]                      wbs_node_mem_addr,
    input  logic [31:0]                      wbs_node_mem_wdata,
    output logic [31:0]                      wbs_node_mem_rdata,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] in_patch,
    input  logic [IDX_WIDTH-1:0]             in_idx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LEAF_ADDRW-1:0]            out_leaf,
    output logic [IDX_WIDTH-1:0]             out_idx,
    output logic                             busy
);

    localparam int LVLW  = $clog2(LEAF_ADDRW + 1);
    localparam int NODEW = LEAF_ADDRW + 1;

    logic [1:0]                      state_q;
    logic [LVLW-1:0]                 level_q;
    logic [NODEW-1:0]                node_q;
    logic [NODEW-1:0]                node_next;
    logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_q;
    logic [IDX_WIDTH-1:0]            idx_q;
    logic [LEAF_ADDRW-1:0]           out_leaf_q;
    logic [IDX_WIDTH-1:0]            out_idx_q;

    logic [NODE_DIMW-1:0]            walk_dim;
    logic [NODE_DIMW-1:0]            dim_sel;
    logic [DATA_WIDTH-1:0]           walk_med;
    logic [DATA_WIDTH-1:0]           elem;
    logic                            go_right;
    logic                            unused_bus_bits;

    // Only the node index and the dim/median fields of the bus word matter
    assign unused_bus_bits = ^{wbs_node_mem_addr[31:LEAF_ADDRW],
                               wbs_node_mem_wdata[31:DATA_WIDTH+NODE_DIMW]};

    kd_node_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAF_ADDRW (LEAF_ADDRW)
    ) u_node_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wbs_node_mem_web),
        .addr      (wbs_node_mem_addr[LEAF_ADDRW-1:0]),
        .wr_dim    (wbs_node_mem_wdata[DATA_WIDTH +: NODE_DIMW]),
        .wr_med    (wbs_node_mem_wdata[DATA_WIDTH-1:0]),
        .rd_data   (wbs_node_mem_rdata),
        .walk_addr (node_q[LEAF_ADDRW-1:0]),
        .walk_dim  (walk_dim),
        .walk_med  (walk_med)
    );

    // Pick the patch element named by the current node and decide the branch
    always_comb begin
        dim_sel   = clamp_dim(walk_dim, PATCH_SIZE);
        elem      = patch_q[int'(dim_sel)*DATA_WIDTH +: DATA_WIDTH];
        go_right  = (elem >= walk_med);
        node_next = {node_q[NODEW-2:0], go_right};
    end

    // Control FSM: accept a query, descend one level per cycle, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            node_q     <= '0;
            patch_q    <= '0;
            idx_q      <= '0;
            out_leaf_q <= '0;
            out_idx_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        patch_q <= in_patch;
                        idx_q   <= in_idx;
                        node_q  <= NODEW'(1);
                        level_q <= '0;
                        state_q <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (level_q == LVLW'(LEAF_ADDRW)) begin
                        // node_q now sits in NUM_LEAVES..2*NUM_LEAVES-1; low bits are the leaf
                        out_leaf_q <= node_q[LEAF_ADDRW-1:0];
                        out_idx_q  <= idx_q;
                        state_q    <= ST_RESULT;
                    end else begin
                        node_q  <= node_next;
                        level_q <= level_q + LVLW'(1);
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_RESULT);
    assign out_leaf  = out_leaf_q;
    assign out_idx   = out_idx_q;

endmodule
